// File: rtl/bt_cmd_receiver.sv
// -----------------------------------------------------------------------------
// bt_cmd_receiver
//
// UART receiver (8N1, LSB first) for the HM-10 module, followed by a command
// parser for the feeder:
//   'F'            -> feed_req strobe (dispense now)
//   'P' d          -> por_valid / por_value = d   (0 <= d <= MAX_PORCIONES)
//   'T' m m s s    -> time_valid / set_min, set_sec (MM 00-59, SS 00-59)
//   CR / LF        -> ignored between commands
// Anything else, a framing error or an idle timeout in the middle of a
// command produces a cmd_err strobe, and the parser starts over.
//
// Handshake: every *_valid / *_req / *_err output is a one-cycle strobe with
// no back-pressure. The data outputs that go with a strobe (rx_data,
// por_value, set_min, set_sec) change only in the cycle their strobe is high
// and then hold until the next one.
//
// Ports
//   clk_1       in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   bt_rx       in   UART line, idle high, asynchronous to clk_1
//   rx_data     out  [7:0] last correctly framed byte
//   rx_valid    out  strobe, rx_data updated
//   frame_err   out  strobe, stop bit sampled low
//   feed_req    out  strobe, dispense now
//   por_valid   out  strobe, por_value loaded
//   por_value   out  [2:0] portion count
//   time_valid  out  strobe, set_min/set_sec loaded
//   set_min     out  [5:0] minutes 0-59
//   set_sec     out  [5:0] seconds 0-59
//   cmd_err     out  strobe, illegal byte or parser timeout
//   busy        out  a frame or a multi-byte command is in progress
// -----------------------------------------------------------------------------
module bt_cmd_receiver #(
    parameter int CLK_FREQ      = 50_000_000,
    parameter int BAUD          = 9600,
    parameter int MAX_PORCIONES = 6,
    parameter int TIMEOUT_BITS  = 20
) (
    input  logic       clk_1,
    input  logic       rst_n,
    input  logic       bt_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       feed_req,
    output logic       por_valid,
    output logic [2:0] por_value,
    output logic       time_valid,
    output logic [5:0] set_min,
    output logic [5:0] set_sec,
    output logic       cmd_err,
    output logic       busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int TMO_LIMIT    = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TMO_W        = $clog2(TMO_LIMIT + 1);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(CLKS_PER_BIT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_LIMIT - 1);
    localparam logic [3:0]       MAX_DIG  = 4'(MAX_PORCIONES);

    // ------------------------------------------------------------------
    // Input synchronizer. rx_prev is a third stage used only for falling
    // edge detection; all three reset to the idle (high) line level so a
    // reset release never looks like a start bit.
    // ------------------------------------------------------------------
    logic rx_meta, rx_sync, rx_prev;

    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= bt_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    rx_state_t        rx_state, rx_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       bit_idx, bit_next;
    logic [7:0]       shift, shift_next;
    logic             valid_set, ferr_set;

    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            rx_state  <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            rx_data   <= '0;
        end else begin
            rx_state  <= rx_next;
            cnt       <= cnt_next;
            bit_idx   <= bit_next;
            shift     <= shift_next;
            rx_valid  <= valid_set;
            frame_err <= ferr_set;
            if (valid_set) rx_data <= shift;
        end
    end

    always_comb begin
        rx_next    = rx_state;
        cnt_next   = cnt;
        bit_next   = bit_idx;
        shift_next = shift;
        valid_set  = 1'b0;
        ferr_set   = 1'b0;
        case (rx_state)
            IDLE: begin
                cnt_next = '0;
                bit_next = '0;
                if (rx_prev && !rx_sync) rx_next = START;
            end
            START: begin
                // Mid-start-bit check: a line already back high was a glitch.
                if (cnt == CNT_HALF) begin
                    cnt_next = '0;
                    rx_next  = rx_sync ? IDLE : DATA;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == CNT_BIT) begin
                    cnt_next   = '0;
                    shift_next = {rx_sync, shift[7:1]};
                    if (bit_idx == 3'd7) rx_next = STOP;
                    else                 bit_next = bit_idx + 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            STOP: begin
                // Sample at CNT_BIT, leave one cycle later. Staying in STOP
                // during the rx_valid cycle keeps busy continuous while the
                // parser picks up the byte.
                if (cnt == CNT_BIT) begin
                    valid_set = rx_sync;
                    ferr_set  = !rx_sync;
                    cnt_next  = cnt + 1'b1;
                end else if (cnt == CNT_END) begin
                    cnt_next = '0;
                    rx_next  = IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: rx_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Command parser FSM
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {P_IDLE, P_POR, P_T0, P_T1, P_T2, P_T3} p_state_t;

    p_state_t         p_state, p_next;
    logic [TMO_W-1:0] tmo_cnt, tmo_next;
    logic [3:0]       min_t, min_u, sec_t;
    logic             feed_set, por_set, time_set, cerr_set;
    logic             is_digit;
    logic [3:0]       digit;

    assign digit    = rx_data[3:0];
    assign is_digit = (rx_data[7:4] == 4'h3) && (rx_data[3:0] <= 4'd9);

    function automatic logic [5:0] two_digits(input logic [3:0] tens,
                                              input logic [3:0] units);
        logic [5:0] t;
        t = {2'b00, tens};
        return (t << 3) + (t << 1) + {2'b00, units};
    endfunction

    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            p_state    <= P_IDLE;
            tmo_cnt    <= '0;
            min_t      <= '0;
            min_u      <= '0;
            sec_t      <= '0;
            feed_req   <= 1'b0;
            por_valid  <= 1'b0;
            time_valid <= 1'b0;
            cmd_err    <= 1'b0;
            por_value  <= '0;
            set_min    <= '0;
            set_sec    <= '0;
        end else begin
            p_state    <= p_next;
            tmo_cnt    <= tmo_next;
            feed_req   <= feed_set;
            por_valid  <= por_set;
            time_valid <= time_set;
            cmd_err    <= cerr_set;
            // Digits are captured unconditionally; an invalid one aborts the
            // command, so a stale capture is never used.
            if (rx_valid && p_state == P_T0) min_t <= digit;
            if (rx_valid && p_state == P_T1) min_u <= digit;
            if (rx_valid && p_state == P_T2) sec_t <= digit;
            if (por_set) por_value <= digit[2:0];
            if (time_set) begin
                set_min <= two_digits(min_t, min_u);
                set_sec <= two_digits(sec_t, digit);
            end
        end
    end

    always_comb begin
        p_next   = p_state;
        tmo_next = tmo_cnt;
        feed_set = 1'b0;
        por_set  = 1'b0;
        time_set = 1'b0;
        cerr_set = 1'b0;
        if (rx_valid) begin
            tmo_next = '0;
            case (p_state)
                P_IDLE: begin
                    case (rx_data)
                        8'h46:        feed_set = 1'b1;
                        8'h50:        p_next   = P_POR;
                        8'h54:        p_next   = P_T0;
                        8'h0D, 8'h0A: ;
                        default:      cerr_set = 1'b1;
                    endcase
                end
                P_POR: begin
                    if (is_digit && digit <= MAX_DIG) por_set  = 1'b1;
                    else                              cerr_set = 1'b1;
                    p_next = P_IDLE;
                end
                P_T0: begin
                    if (is_digit && digit <= 4'd5) p_next = P_T1;
                    else begin cerr_set = 1'b1; p_next = P_IDLE; end
                end
                P_T1: begin
                    if (is_digit) p_next = P_T2;
                    else begin cerr_set = 1'b1; p_next = P_IDLE; end
                end
                P_T2: begin
                    if (is_digit && digit <= 4'd5) p_next = P_T3;
                    else begin cerr_set = 1'b1; p_next = P_IDLE; end
                end
                P_T3: begin
                    if (is_digit) time_set = 1'b1;
                    else          cerr_set = 1'b1;
                    p_next = P_IDLE;
                end
                default: p_next = P_IDLE;
            endcase
        end else if (p_state != P_IDLE) begin
            if (frame_err || tmo_cnt == TMO_LAST) begin
                cerr_set = 1'b1;
                p_next   = P_IDLE;
                tmo_next = '0;
            end else begin
                tmo_next = tmo_cnt + 1'b1;
            end
        end else begin
            tmo_next = '0;
        end
    end

    assign busy = (rx_state != IDLE) || (p_state != P_IDLE);

endmodule

// File: tb/tb_bt_cmd_receiver.sv
// Bench for bt_cmd_receiver with a short bit period (16 clocks per bit) so
// the full command set plus random traffic stays well inside the cycle budget.
module tb_bt_cmd_receiver;

  localparam int CLK_FREQ  = 1_600_000;
  localparam int BAUD      = 100_000;
  localparam int MAX_POR   = 6;
  localparam int TMO_BITS  = 20;
  localparam int CPB       = CLK_FREQ / BAUD;
  localparam int TMO_LIMIT = TMO_BITS * CPB;
  localparam int W         = 24;

  localparam logic [3:0] K_RX   = 4'd1;
  localparam logic [3:0] K_FERR = 4'd2;
  localparam logic [3:0] K_FEED = 4'd3;
  localparam logic [3:0] K_POR  = 4'd4;
  localparam logic [3:0] K_TIME = 4'd5;
  localparam logic [3:0] K_CERR = 4'd6;

  logic       clk_1 = 1'b0;
  logic       rst_n = 1'b0;
  logic       bt_rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, feed_req, por_valid, time_valid, cmd_err, busy;
  logic [2:0] por_value;
  logic [5:0] set_min, set_sec;

  bt_cmd_receiver #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .MAX_PORCIONES(MAX_POR), .TIMEOUT_BITS(TMO_BITS)
  ) dut (
    .clk_1(clk_1), .rst_n(rst_n), .bt_rx(bt_rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .feed_req(feed_req), .por_valid(por_valid), .por_value(por_value),
    .time_valid(time_valid), .set_min(set_min), .set_sec(set_sec),
    .cmd_err(cmd_err), .busy(busy)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk_1 = ~clk_1;
  int cyc = 0;
  always @(posedge clk_1) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [W-1:0] ev(input logic [3:0] k, input logic [7:0] a,
                                      input logic [5:0] b, input logic [5:0] c);
    return {k, a, b, c};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input string name, input logic [W-1:0] got);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: got event %h, expected no event (cycle %0d)", name, got, cyc);
    end else begin
      check(name, 32'(got), 32'(exp_q.pop_front()));
    end
  endtask

  // ---------------- monitor ----------------
  int last_rx_cyc = 0;
  int last_cerr_cyc = 0;
  int n_cerr = 0;
  int n_strobes;
  bit watch_on = 0;
  int watch_from = 0;
  int busy_drops = 0;
  bit tv_seen = 0;

  always @(negedge clk_1) begin
    if (rst_n) begin
      n_strobes = int'(feed_req) + int'(por_valid) + int'(time_valid) + int'(cmd_err);
      if (n_strobes > 1) check("one_cmd_strobe", n_strobes, 1);
      if (rx_valid) begin
        last_rx_cyc = cyc;
        expect_ev("rx_valid", ev(K_RX, rx_data, 6'd0, 6'd0));
      end
      if (frame_err) expect_ev("frame_err", ev(K_FERR, 8'd0, 6'd0, 6'd0));
      if (feed_req) begin
        expect_ev("feed_req", ev(K_FEED, 8'd0, 6'd0, 6'd0));
        check("feed_latency", cyc - last_rx_cyc, 1);
      end
      if (por_valid) begin
        expect_ev("por_valid", ev(K_POR, {5'd0, por_value}, 6'd0, 6'd0));
        check("por_latency", cyc - last_rx_cyc, 1);
      end
      if (time_valid) begin
        expect_ev("time_valid", ev(K_TIME, 8'd0, set_min, set_sec));
        check("time_latency", cyc - last_rx_cyc, 1);
      end
      if (cmd_err) begin
        last_cerr_cyc = cyc;
        n_cerr++;
        expect_ev("cmd_err", ev(K_CERR, 8'd0, 6'd0, 6'd0));
      end
      if (watch_on && cyc >= watch_from) begin
        if (time_valid) begin
          watch_on = 0;
          tv_seen = 1;
        end else if (!busy) begin
          busy_drops++;
        end
      end
    end
  end

  // ---------------- reference model (command level) ----------------
  logic [7:0] pend_q[$];

  function automatic logic [5:0] num2(input logic [7:0] t, input logic [7:0] u);
    return 6'((int'(t) - 48) * 10 + (int'(u) - 48));
  endfunction

  task automatic model_byte(input logic [7:0] b, input bit stop_ok);
    int pos;
    int maxd;
    if (!stop_ok) begin
      exp_q.push_back(ev(K_FERR, 8'd0, 6'd0, 6'd0));
      if (pend_q.size() > 0) begin
        exp_q.push_back(ev(K_CERR, 8'd0, 6'd0, 6'd0));
        pend_q.delete();
      end
      return;
    end
    exp_q.push_back(ev(K_RX, b, 6'd0, 6'd0));
    if (pend_q.size() == 0) begin
      if (b == "F") exp_q.push_back(ev(K_FEED, 8'd0, 6'd0, 6'd0));
      else if (b == "P" || b == "T") pend_q.push_back(b);
      else if (b != 8'h0D && b != 8'h0A) exp_q.push_back(ev(K_CERR, 8'd0, 6'd0, 6'd0));
    end else if (pend_q[0] == "P") begin
      if (b >= "0" && int'(b) <= 48 + MAX_POR) exp_q.push_back(ev(K_POR, b - 8'd48, 6'd0, 6'd0));
      else exp_q.push_back(ev(K_CERR, 8'd0, 6'd0, 6'd0));
      pend_q.delete();
    end else begin
      pos = pend_q.size() - 1;
      maxd = (pos % 2 == 0) ? 5 : 9;
      if (b >= "0" && int'(b) <= 48 + maxd) begin
        pend_q.push_back(b);
        if (pend_q.size() == 5) begin
          exp_q.push_back(ev(K_TIME, 8'd0, num2(pend_q[1], pend_q[2]), num2(pend_q[3], pend_q[4])));
          pend_q.delete();
        end
      end else begin
        exp_q.push_back(ev(K_CERR, 8'd0, 6'd0, 6'd0));
        pend_q.delete();
      end
    end
  endtask

  task automatic model_timeout();
    if (pend_q.size() > 0) begin
      exp_q.push_back(ev(K_CERR, 8'd0, 6'd0, 6'd0));
      pend_q.delete();
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_bit(input logic v);
    bt_rx = v;
    repeat (CPB) @(negedge clk_1);
  endtask

  task automatic send_byte(input logic [7:0] d, input bit stop_ok, input int gap_bits);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop_ok);
    if (!stop_ok) drive_bit(1'b1);
    repeat (gap_bits) drive_bit(1'b1);
  endtask

  function automatic logic [29:0] all_outs();
    return {rx_data, rx_valid, frame_err, feed_req, por_valid, por_value,
            time_valid, set_min, set_sec, cmd_err, busy};
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]   data;
    bit           stop_ok;
    logic [W-1:0] cmd;      // expected command event, 0 = none
    logic [3:0]   por_chk;  // expected por_value after the row, F = skip
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [7:0] d, input bit ok, input logic [W-1:0] c, input logic [3:0] pc);
    vec_t v;
    v.data = d; v.stop_ok = ok; v.cmd = c; v.por_chk = pc;
    tbl.push_back(v);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] none;
    logic [W-1:0] cerr;
    int c0;
    int dly;
    logic [7:0] b;
    bit ok;
    bit long_gap;
    none = '0;
    cerr = ev(K_CERR, 8'd0, 6'd0, 6'd0);

    add("F", 1, ev(K_FEED, 8'd0, 6'd0, 6'd0), 4'hF);
    add("P", 1, none, 4'hF);
    add("4", 1, ev(K_POR, 8'd4, 6'd0, 6'd0), 4'd4);
    add("P", 1, none, 4'hF);
    add("9", 1, cerr, 4'd4);
    add("T", 1, none, 4'hF);
    add("0", 1, none, 4'hF);
    add("1", 1, none, 4'hF);
    add("3", 1, none, 4'hF);
    add("0", 1, ev(K_TIME, 8'd0, 6'd1, 6'd30), 4'hF);
    add(8'h46, 0, none, 4'hF);
    add("P", 1, none, 4'hF);
    add("6", 1, ev(K_POR, 8'd6, 6'd0, 6'd0), 4'd6);
    add("P", 1, none, 4'hF);
    add("7", 1, cerr, 4'd6);
    add("T", 1, none, 4'hF);
    add("5", 1, none, 4'hF);
    add("9", 1, none, 4'hF);
    add("5", 1, none, 4'hF);
    add("9", 1, ev(K_TIME, 8'd0, 6'd59, 6'd59), 4'hF);
    add("T", 1, none, 4'hF);
    add("6", 1, cerr, 4'hF);
    add(8'h0D, 1, none, 4'hF);
    add(8'h0A, 1, none, 4'hF);
    add("X", 1, cerr, 4'hF);
    add("T", 1, none, 4'hF);
    add("2", 1, none, 4'hF);
    add(8'hAA, 0, cerr, 4'hF);

    // reset state
    #1 check("reset_outputs", 32'(all_outs()), 32'd0);
    repeat (3) @(negedge clk_1);
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk_1);
    check("idle_busy", 32'(busy), 32'd0);

    // table
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].stop_ok) exp_q.push_back(ev(K_RX, tbl[i].data, 6'd0, 6'd0));
      else exp_q.push_back(ev(K_FERR, 8'd0, 6'd0, 6'd0));
      if (tbl[i].cmd != none) exp_q.push_back(tbl[i].cmd);
      send_byte(tbl[i].data, tbl[i].stop_ok, 2);
      if (tbl[i].por_chk != 4'hF) check("por_value_hold", 32'(por_value), 32'(tbl[i].por_chk));
    end
    check("tbl_por_hold", 32'(por_value), 32'd6);
    check("tbl_min_hold", 32'(set_min), 32'd59);
    check("tbl_sec_hold", 32'(set_sec), 32'd59);
    check("tbl_rx_data_hold", 32'(rx_data), 32'h32);
    check("tbl_busy_end", 32'(busy), 32'd0);

    // short low glitch, then 'T','0' and an idle timeout
    bt_rx = 1'b0;
    repeat (5) @(negedge clk_1);
    bt_rx = 1'b1;
    repeat (3 * CPB) @(negedge clk_1);
    check("glitch_busy", 32'(busy), 32'd0);
    model_byte("T", 1);
    model_byte("0", 1);
    send_byte("T", 1, 2);
    send_byte("0", 1, 2);
    check("pending_busy", 32'(busy), 32'd1);
    model_timeout();
    c0 = n_cerr;
    for (int i = 0; i < TMO_LIMIT + 4 * CPB && n_cerr == c0; i++) @(negedge clk_1);
    check("timeout_seen", 32'(n_cerr - c0), 32'd1);
    dly = last_cerr_cyc - last_rx_cyc;
    check("timeout_delay", 32'(dly >= TMO_LIMIT && dly <= TMO_LIMIT + 2), 32'd1);
    repeat (2) @(negedge clk_1);
    check("timeout_busy", 32'(busy), 32'd0);

    // "T0130" with busy held from the first start bit until time_valid
    watch_from = cyc + 4;
    watch_on = 1;
    foreach (tbl[i]) if (i >= 5 && i <= 9) model_byte(tbl[i].data, 1);
    foreach (tbl[i]) if (i >= 5 && i <= 9) send_byte(tbl[i].data, 1, 1);
    repeat (2 * CPB) @(negedge clk_1);
    check("t0130_time_valid", 32'(tv_seen), 32'd1);
    check("t0130_busy_drops", 32'(busy_drops), 32'd0);
    watch_on = 0;

    // reset in the middle of the data bits of 'F'
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    repeat (CPB / 2) @(negedge clk_1);
    rst_n = 1'b0;
    #1 check("midframe_reset_outputs", 32'(all_outs()), 32'd0);
    bt_rx = 1'b1;
    repeat (3) @(negedge clk_1);
    rst_n = 1'b1;
    pend_q.delete();
    repeat (2 * CPB) @(negedge clk_1);
    model_byte("P", 1);
    model_byte("3", 1);
    send_byte("P", 1, 2);
    send_byte("3", 1, 2);
    check("post_reset_por", 32'(por_value), 32'd3);

    // random traffic against the model
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0: b = "F";
        1: b = "P";
        2, 9: b = "T";
        3, 4, 5, 8: b = 8'(48 + $urandom_range(0, 9));
        6: b = ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A;
        default: b = 8'($urandom_range(0, 255));
      endcase
      ok = ($urandom_range(0, 9) != 0);
      long_gap = ($urandom_range(0, 9) == 0);
      model_byte(b, ok);
      if (long_gap) model_timeout();
      send_byte(b, ok, long_gap ? 25 : int'($urandom_range(0, 3)));
    end
    model_timeout();
    repeat (25 * CPB) @(negedge clk_1);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("final_busy", 32'(busy), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
